// File: rtl/shift_deser.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words from a framed serial stream and
// presents them on a valid/ready output with sticky overrun and pulsed framing-error flags.
module shift_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic             frame_err,
  input  logic             err_clr
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] data_out_q;
  logic             data_valid_q;
  logic             overrun_q;
  logic             frame_err_q;
  logic             last_bit;
  logic             slot_free;

  // Shift register contents after capturing the current sin bit.
  always_comb begin
    shift_d = shift_q;
    if (MSB_FIRST) begin
      shift_d = {shift_q[WIDTH-2:0], sin};
    end else begin
      shift_d = {sin, shift_q[WIDTH-1:1]};
    end
  end

  assign last_bit  = (cnt_q == CntW'(WIDTH - 1));
  assign slot_free = !data_valid_q || data_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (err_clr) begin
        overrun_q <= 1'b0;
      end
      if (data_valid_q && data_ready) begin
        data_valid_q <= 1'b0;
      end
      // Later assignments below deliberately override the clears above.
      if (sin_valid) begin
        unique case (state_q)
          StIdle: begin
            if (frame_start) begin
              shift_q <= shift_d;
              cnt_q   <= CntW'(1);
              state_q <= StShift;
            end
          end
          StShift: begin
            shift_q <= shift_d;
            if (frame_start) begin
              frame_err_q <= 1'b1;
              cnt_q       <= CntW'(1);
            end else if (last_bit) begin
              state_q <= StIdle;
              cnt_q   <= '0;
              if (slot_free) begin
                data_out_q   <= shift_d;
                data_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_shift_deser.sv
// Randomized scoreboard bench for shift_deser: drives an MSB-first and an LSB-first instance with
// the same serial stream and checks both against a word-level reference model.
module tb_shift_deser;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         data_ready = 1'b0;
  logic         err_clr = 1'b0;
  logic [W-1:0] dout_m, dout_l;
  logic         dv_m, dv_l, ovr_m, ovr_l, fe_m, fe_l;

  always #5 clk = ~clk;

  shift_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
    .data_out(dout_m), .data_valid(dv_m), .data_ready(data_ready), .overrun(ovr_m),
    .frame_err(fe_m), .err_clr(err_clr)
  );

  shift_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
    .data_out(dout_l), .data_valid(dv_l), .data_ready(data_ready), .overrun(ovr_l),
    .frame_err(fe_l), .err_clr(err_clr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: received bits of the word in progress, output slot, flags.
  logic [W-1:0] q_m[$];
  logic [W-1:0] q_l[$];
  bit           cur[$];
  bit           in_word = 1'b0;
  bit           slot = 1'b0;
  bit           m_ovr = 1'b0;
  int           exp_fe = 0;
  int           seen_fe_m = 0;
  int           seen_fe_l = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model the coming clock edge from the inputs now applied, then advance past it.
  task automatic tick();
    bit done = 1'b0;
    bit new_ovr = 1'b0;
    if (rst) begin
      cur.delete();
      in_word = 1'b0;
      slot    = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      if (sin_valid) begin
        if (frame_start) begin
          if (in_word) exp_fe++;
          cur.delete();
          cur.push_back(sin);
          in_word = 1'b1;
        end else if (in_word) begin
          cur.push_back(sin);
          if (cur.size() == W) begin
            done    = 1'b1;
            in_word = 1'b0;
          end
        end
      end
      if (done) begin
        if (!slot || data_ready) begin
          logic [W-1:0] vm = '0;
          logic [W-1:0] vl = '0;
          for (int i = 0; i < W; i++) begin
            vm = W'((vm << 1) | W'(cur[i]));
            vl[i] = cur[i];
          end
          q_m.push_back(vm);
          q_l.push_back(vl);
          slot = 1'b1;
        end else begin
          new_ovr = 1'b1;
        end
      end else if (slot && data_ready) begin
        slot = 1'b0;
      end
      if (err_clr) m_ovr = 1'b0;
      if (new_ovr) m_ovr = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b, input bit fs, input int gap);
    sin         = b;
    frame_start = fs;
    sin_valid   = 1'b1;
    tick();
    sin_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      sin         = 1'($urandom);
      frame_start = 1'($urandom);
      tick();
    end
    frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] v, input int gmin, input int gmax);
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(v[i], i == W - 1, int'($urandom_range(gmax, gmin)));
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " dout_m"}, 32'(dout_m), 32'(0));
    check({tag, " dout_l"}, 32'(dout_l), 32'(0));
    check({tag, " dv"}, {dv_m, dv_l}, {1'b0, 1'b0});
    check({tag, " ovr"}, {ovr_m, ovr_l}, {1'b0, 1'b0});
    check({tag, " fe"}, {fe_m, fe_l}, {1'b0, 1'b0});
  endtask

  // Monitor: pops and compares on every output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (dv_m && data_ready) begin
        if (q_m.size() == 0) check("unexpected word msb", 32'(dout_m), 32'hffff_ffff);
        else check("word msb", 32'(dout_m), 32'(q_m.pop_front()));
      end
      if (dv_l && data_ready) begin
        if (q_l.size() == 0) check("unexpected word lsb", 32'(dout_l), 32'hffff_ffff);
        else check("word lsb", 32'(dout_l), 32'(q_l.pop_front()));
      end
      if (fe_m) seen_fe_m++;
      if (fe_l) seen_fe_l++;
    end
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_outputs("reset");

    data_ready = 1'b1;
    send_word(8'hA5, 0, 0);
    check("A5 valid", {dv_m, dv_l}, {1'b1, 1'b1});
    tick();
    check("A5 one cycle", {dv_m, dv_l}, {1'b0, 1'b0});
    send_word(8'h80, 0, 1);
    tick();

    // Backpressure and overrun.
    data_ready = 1'b0;
    send_word(8'h3C, 0, 0);
    send_word(8'hC3, 0, 0);
    check("ovr set", 32'(ovr_m), 32'(m_ovr));
    check("ovr set lsb", 32'(ovr_l), 32'(1));
    check("dout held", 32'(dout_m), 32'(8'h3C));
    data_ready = 1'b1;
    tick();
    check("dv dropped", {dv_m, dv_l}, {1'b0, 1'b0});
    check("ovr sticky", 32'(ovr_m), 32'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovr cleared", {ovr_m, ovr_l}, {m_ovr, m_ovr});

    send_word(8'h81, 3, 3);
    tick();
    check("gap no fe", 32'(seen_fe_m), 32'(exp_fe));

    // Restart after a partial word.
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), i == 0, 0);
    send_word(8'h5A, 0, 0);
    tick();
    check("restart fe", 32'(seen_fe_m), 32'(exp_fe));
    check("restart fe lsb", 32'(seen_fe_l), 32'(1));

    // Simultaneous accept and complete.
    data_ready = 1'b0;
    send_word(8'h11, 0, 0);
    for (int i = W - 1; i > 0; i--) send_bit(1'(8'h22 >> i), i == W - 1, 0);
    data_ready = 1'b1;
    send_bit(1'b0, 1'b0, 0);
    check("simul dout", 32'(dout_m), 32'(8'h22));
    check("simul dv", 32'(dv_m), 32'(1));
    check("simul ovr", {ovr_m, ovr_l}, {m_ovr, 1'b0});
    tick();

    // Mid-word reset.
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outputs("midreset");
    send_word(8'hF0, 0, 1);
    tick();

    // Randomized frames with gaps, stray idle bits and aborted partial words.
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 4) == 0) send_bit(1'($urandom), 1'b0, int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        int k = int'($urandom_range(1, W - 1));
        for (int i = 0; i < k; i++) send_bit(1'($urandom), i == 0, int'($urandom_range(0, 1)));
      end
      send_word(W'($urandom), 0, 2);
    end
    repeat (4) tick();

    check("queue msb empty", 32'(q_m.size()), 32'(0));
    check("queue lsb empty", 32'(q_l.size()), 32'(0));
    check("fe count msb", 32'(seen_fe_m), 32'(exp_fe));
    check("fe count lsb", 32'(seen_fe_l), 32'(exp_fe));
    check("final ovr", {ovr_m, ovr_l}, {m_ovr, m_ovr});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_deser.md
Name: shift_deser

Overview:
- Serial-in/parallel-out receiver: the far end of a left-shifting serial source.
- Bits arrive MSB-first on `sin`, qualified by `sin_valid`. `frame_start` marks the first bit of each word.
- Assembles WIDTH-bit words, presents them on a valid/ready parallel output, and flags overrun and framing errors.
- Sits between a serial link and any parallel consumer in the design.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in `data_out[WIDTH-1]`; 0 = first bit lands in `data_out[0]`.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  `sin` is sampled only when high.
- frame_start  input  1  with `sin_valid`, marks the current bit as bit 0 of a new word.
- data_out  output  WIDTH  assembled word; stable while `data_valid` is high.
- data_valid  output  1  word available.
- data_ready  input  1  consumer accepts the word when `data_valid` and `data_ready` are both high.
- overrun  output  1  sticky: a completed word was dropped.
- frame_err  output  1  one-cycle pulse: a partial word was discarded.
- err_clr  input  1  clears `overrun`.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - `data_out` = 0, `data_valid` = 0, `overrun` = 0, `frame_err` = 0.
  - Bit counter = 0, shift register = 0, FSM = IDLE.
  - Reset overrides every other input, including a word in progress, which is discarded silently with no `frame_err`.
- FSM states: IDLE, SHIFT.
  - IDLE: bits with `sin_valid` = 1 and `frame_start` = 0 are ignored.
  - IDLE, `sin_valid` and `frame_start` both high: capture the bit, counter = 1, go to SHIFT.
  - SHIFT, `sin_valid` = 1 and `frame_start` = 0: capture the bit, counter++.
  - SHIFT, `sin_valid` = 0: hold; no timeout.
  - SHIFT, `sin_valid` and `frame_start` both high: `frame_err` pulses high the next cycle. The partial word is dropped. The current bit becomes bit 0 of the new word (counter = 1, stay in SHIFT).
- Bit placement:
  - MSB_FIRST = 1: shift register shifts left, new bit enters at LSB.
  - MSB_FIRST = 0: shift register shifts right, new bit enters at MSB.
- Word completion: the edge that captures bit WIDTH-1 (counter reaches WIDTH) completes the word.
  - FSM returns to IDLE and the counter resets to 0.
  - If the output slot is free, the word loads into `data_out` on that same edge and `data_valid` = 1 from that edge on. Latency from the last bit's sampling edge to `data_valid` is 0 cycles (visible in the following cycle).
  - WIDTH = 1-bit frames are not supported.
- Output slot:
  - Free when `data_valid` = 0, or when `data_valid` = 1 and `data_ready` = 1 on the completion edge (simultaneous accept and complete). In the simultaneous case the new word replaces the old one and `data_valid` stays 1.
  - On accept with no new word completing, `data_valid` goes to 0 next edge.
- Overrun: a word completes while `data_valid` = 1 and `data_ready` = 0.
  - The new word is dropped and `data_out` is unchanged.
  - `overrun` is set and stays 1 until `err_clr` or `rst`.
  - If `err_clr` and a new overrun occur on the same edge, set wins.
- `frame_start` on the bit that would complete the word (counter = WIDTH-1): treated as a restart, so `frame_err` pulses and no word completes.
- `data_ready` while `data_valid` = 0: no effect.
- `sin` and `frame_start` are don't-care when `sin_valid` = 0.

Test Plan:
- Word and reset: rst for 2 cycles, then 8 valid bits 1,0,1,0,0,1,0,1 with `frame_start` on the first, `data_ready` = 1 -> `data_valid` high for 1 cycle after the 8th bit, `data_out` = 8'hA5. Before the first word, all outputs = 0.
- LSB-first: MSB_FIRST = 0, same bit sequence -> `data_out` = 8'hA5 reversed = 8'hA5 (palindrome check). Then send 8'h01 pattern 1,0,0,0,0,0,0,0 -> `data_out` = 8'h01.
- Backpressure and overrun: `data_ready` = 0, send 8'h3C then 8'hC3.
  - `data_out` stays 8'h3C and `overrun` = 1.
  - Raise `data_ready` -> `data_valid` drops.
  - Pulse `err_clr` -> `overrun` = 0.
- Gapped bits: `sin_valid` low for 3 cycles between each bit of 8'h81 -> `data_out` = 8'h81, no `frame_err`.
- Restart: 4 bits of a word, then `frame_start` with 8 bits of 8'h5A -> one-cycle `frame_err` pulse, `data_out` = 8'h5A.
- Simultaneous accept and complete: hold `data_valid` = 1 (8'h11) and assert `data_ready` on the edge completing 8'h22 -> `data_out` = 8'h22, `data_valid` stays 1, `overrun` = 0.
- Mid-word reset: assert rst after 5 bits -> all outputs 0. The next full 8'hF0 frame is received correctly.
